// File: rtl/queue_ptr.sv
// queue_ptr: AW-bit wrap-around up-counter used as a FIFO head or tail pointer.
module queue_ptr #(
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          Clr,
  input  logic          E,
  output logic [AW-1:0] Q
);

  logic [AW-1:0] r_q;

  // Pointer register: synchronous clear, increment on enable, natural wrap at 2**AW.
  always_ff @(posedge CLK) begin
    if (Clr) begin
      r_q <= '0;
    end else if (E) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/queue_nb.sv
// queue_nb: circular FIFO with registered dequeue data, occupancy count,
// registered FULL/EMPTY flags and one-cycle VALID/OVF/UNF pulses.
module queue_nb #(
  parameter int n  = 7,
  parameter int AW = 3
) (
  input  logic        CLK,
  input  logic        Clr,
  input  logic        PUSH,
  input  logic        POP,
  input  logic [n:0]  DIN,
  output logic [n:0]  DOUT,
  output logic        VALID,
  output logic        FULL,
  output logic        EMPTY,
  output logic [AW:0] CNT,
  output logic        OVF,
  output logic        UNF
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  logic [n:0]    r_mem [DEPTH];
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;
  logic [n:0]    r_dout;
  logic          r_valid;
  logic          r_ovf;
  logic          r_unf;

  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW-1:0] w_head;
  logic [AW-1:0] w_tail;
  logic [AW:0]   w_cnt_nxt;

  // Acceptance from pre-edge state; a full queue still accepts a push when a pop frees a slot.
  always_comb begin
    w_push_ok = PUSH & (~r_full | POP);
    w_pop_ok  = POP & ~r_empty;
  end

  // Next occupancy: up on push-only, down on pop-only, else hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_ok && !w_pop_ok) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_pop_ok && !w_push_ok) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  queue_ptr #(.AW(AW)) u_head (
    .CLK (CLK),
    .Clr (Clr),
    .E   (w_pop_ok),
    .Q   (w_head)
  );

  queue_ptr #(.AW(AW)) u_tail (
    .CLK (CLK),
    .Clr (Clr),
    .E   (w_push_ok),
    .Q   (w_tail)
  );

  // Storage write; contents survive reset, but no write happens while Clr is high.
  always_ff @(posedge CLK) begin
    if (!Clr && w_push_ok) begin
      r_mem[w_tail] <= DIN;
    end
  end

  // Count, flags, dequeue data and status pulses.
  always_ff @(posedge CLK) begin
    if (Clr) begin
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == DEPTH_CNT);
      r_empty <= (w_cnt_nxt == '0);
      r_valid <= w_pop_ok;
      r_ovf   <= PUSH & r_full & ~POP;
      r_unf   <= POP & r_empty;
      if (w_pop_ok) begin
        r_dout <= r_mem[w_head];
      end
    end
  end

  assign DOUT  = r_dout;
  assign VALID = r_valid;
  assign FULL  = r_full;
  assign EMPTY = r_empty;
  assign CNT   = r_cnt;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

endmodule

// File: tb/tb_queue_nb.sv
// tb_queue_nb: table-driven check of queue_nb (n=7, AW=3) plus hand-written
// sequences for simultaneous push/pop on empty, pointer wrap and mid-run reset.
module tb_queue_nb;

  logic       CLK;
  logic       Clr;
  logic       PUSH;
  logic       POP;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       VALID;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] CNT;
  logic       OVF;
  logic       UNF;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic       clr;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic [7:0] dout;
    logic       valid;
    logic       ovf;
    logic       unf;
    string      name;
  } vec_t;

  vec_t vecs[$];

  queue_nb #(.n(7), .AW(3)) dut (
    .CLK   (CLK),
    .Clr   (Clr),
    .PUSH  (PUSH),
    .POP   (POP),
    .DIN   (DIN),
    .DOUT  (DOUT),
    .VALID (VALID),
    .FULL  (FULL),
    .EMPTY (EMPTY),
    .CNT   (CNT),
    .OVF   (OVF),
    .UNF   (UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void add(input string name, input logic clr, input logic push,
                              input logic pop, input logic [7:0] din, input logic [3:0] cnt,
                              input logic full, input logic empty, input logic [7:0] dout,
                              input logic valid, input logic ovf, input logic unf);
    vec_t v;
    v.name = name; v.clr = clr; v.push = push; v.pop = pop; v.din = din;
    v.cnt = cnt; v.full = full; v.empty = empty; v.dout = dout;
    v.valid = valid; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  // Drive inputs, take one edge, then sample 1 time unit after it.
  task automatic step(input logic clr, input logic push, input logic pop, input logic [7:0] din);
    Clr = clr; PUSH = push; POP = pop; DIN = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] cnt, input logic full,
                       input logic empty, input logic [7:0] dout, input logic valid,
                       input logic ovf, input logic unf);
    logic [15:0] act;
    logic [15:0] exp;
    act = {CNT, FULL, EMPTY, DOUT, VALID, OVF, UNF};
    exp = {cnt, full, empty, dout, valid, ovf, unf};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got CNT=%0d FULL=%b EMPTY=%b DOUT=%h VALID=%b OVF=%b UNF=%b, want CNT=%0d FULL=%b EMPTY=%b DOUT=%h VALID=%b OVF=%b UNF=%b",
               name, CNT, FULL, EMPTY, DOUT, VALID, OVF, UNF,
               cnt, full, empty, dout, valid, ovf, unf);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] last;
    logic [7:0] exp_w;

    n_tests = 0;
    n_fail  = 0;
    Clr = 1'b1; PUSH = 1'b0; POP = 1'b0; DIN = '0;

    // Reset with PUSH/POP asserted: nothing accepted, no error pulses.
    add("reset0", 1, 1, 1, 8'hFF, 0, 0, 1, 8'h00, 0, 0, 0);
    add("reset1", 1, 1, 1, 8'hFF, 0, 0, 1, 8'h00, 0, 0, 0);
    // Fill with 0x11..0x88.
    for (int unsigned k = 1; k <= 8; k++)
      add("fill", 0, 1, 0, 8'(k * 8'h11), 4'(k), k == 8, 0, 8'h00, 0, 0, 0);
    add("ovf", 0, 1, 0, 8'h99, 8, 1, 0, 8'h00, 0, 1, 0);
    // Drain in order.
    for (int unsigned k = 1; k <= 8; k++)
      add("drain", 0, 0, 1, 8'h00, 4'(8 - k), 0, k == 8, 8'(k * 8'h11), 1, 0, 0);
    add("unf", 0, 0, 1, 8'h00, 0, 0, 1, 8'h88, 0, 0, 1);
    add("idle", 0, 0, 0, 8'h00, 0, 0, 1, 8'h88, 0, 0, 0);
    // Refill, then simultaneous push/pop while full.
    for (int unsigned k = 1; k <= 8; k++)
      add("refill", 0, 1, 0, 8'(k * 8'h11), 4'(k), k == 8, 0, 8'h88, 0, 0, 0);
    add("pp_full", 0, 1, 1, 8'hAA, 8, 1, 0, 8'h11, 1, 0, 0);
    for (int unsigned k = 2; k <= 8; k++)
      add("drain2", 0, 0, 1, 8'h00, 4'(9 - k), 0, 0, 8'(k * 8'h11), 1, 0, 0);
    add("drain_aa", 0, 0, 1, 8'h00, 0, 0, 1, 8'hAA, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].din);
      check(vecs[i].name, vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].dout,
            vecs[i].valid, vecs[i].ovf, vecs[i].unf);
    end

    // Simultaneous push/pop on empty: pop rejected, push accepted, no bypass.
    step(0, 1, 1, 8'h5C);
    check("pp_empty", 1, 0, 0, 8'hAA, 0, 0, 1);
    step(0, 0, 1, 8'h00);
    check("pp_empty_pop", 0, 0, 1, 8'h5C, 1, 0, 0);

    // Alternating push/pop across the pointer wrap, checked against a queue model.
    d = 8'h30;
    last = 8'h5C;
    for (int unsigned i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        q.push_back(d);
        step(0, 1, 0, d);
        check("wrap_push", 1, 0, 0, last, 0, 0, 0);
        d = d + 8'h01;
      end else begin
        exp_w = q.pop_front();
        step(0, 0, 1, 8'h00);
        check("wrap_pop", 0, 0, 1, exp_w, 1, 0, 0);
        last = exp_w;
      end
    end

    // Mid-run reset discards queued words.
    step(0, 1, 0, 8'hE1);
    step(0, 1, 0, 8'hE2);
    step(0, 1, 0, 8'hE3);
    check("pre_clr", 3, 0, 0, last, 0, 0, 0);
    step(1, 0, 0, 8'h00);
    check("mid_clr", 0, 0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 1, 8'h00);
    check("post_clr_unf", 0, 0, 1, 8'h00, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
